// File: rtl/bcd_convert_sched.sv
// Time-shared serial binary-to-BCD converter (shift-add-3, one bit per clock)
// with a two-requester round-robin scheduler feeding 7-segment display drivers.
module bcd_convert_sched #(
  parameter int WIDTH = 7,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] bin0,
  input  logic             req1,
  input  logic [WIDTH-1:0] bin1,
  output logic             ack0,
  output logic             ack1,
  output logic             busy,
  output logic             res_valid,
  output logic             res_id,
  output logic [3:0]       hundreds,
  output logic [3:0]       tens,
  output logic [3:0]       units
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic             rr_ptr;
  logic             owner;
  logic             grant;
  logic             winner;
  logic             last_shift;
  logic [CNT_W-1:0] cnt;
  logic [11:0]      acc;
  logic [11:0]      acc_adj;
  logic [WIDTH-1:0] sr;
  logic [WIDTH+11:0] shifted;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // All three nibbles are corrected from their pre-shift values, then the
  // combined {accumulator, shift register} moves left by one bit.
  assign acc_adj    = {add3(acc[11:8]), add3(acc[7:4]), add3(acc[3:0])};
  assign shifted    = {acc_adj, sr} << 1;
  assign last_shift = (cnt == CNT_W'(WIDTH - 1));
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // rr_ptr names the requester that wins a tie; it flips away from each winner.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    winner     = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant      = 1'b1;
          winner     = (req0 && req1) ? rr_ptr : req1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (last_shift) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= 1'b0;
      owner     <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      sr        <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      hundreds  <= '0;
      tens      <= '0;
      units     <= '0;
    end else begin
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      res_valid <= 1'b0;
      if (grant) begin
        sr     <= winner ? bin1 : bin0;
        acc    <= '0;
        cnt    <= '0;
        owner  <= winner;
        rr_ptr <= ~winner;
        ack0   <= ~winner;
        ack1   <= winner;
      end else if (state == SHIFT) begin
        acc <= shifted[WIDTH+11:WIDTH];
        sr  <= shifted[WIDTH-1:0];
        cnt <= cnt + CNT_W'(1);
        if (last_shift) begin
          hundreds  <= shifted[WIDTH+11:WIDTH+8];
          tens      <= shifted[WIDTH+7:WIDTH+4];
          units     <= shifted[WIDTH+3:WIDTH];
          res_id    <= owner;
          res_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_convert_sched.sv
// Scoreboard bench for bcd_convert_sched: expected digits are queued at grant
// time and a negedge monitor pops and compares on every res_valid pulse.
module tb_bcd_convert_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [6:0] bin0 = '0;
  logic [6:0] bin1 = '0;
  logic       ack0, ack1, busy, res_valid, res_id;
  logic [3:0] hundreds, tens, units;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [12:0] sb[$];
  bit          grant_id[$];
  int          grant_cyc[$];

  bcd_convert_sched #(.WIDTH(7), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .bin0(bin0), .req1(req1), .bin1(bin1),
    .ack0(ack0), .ack1(ack1), .busy(busy),
    .res_valid(res_valid), .res_id(res_id),
    .hundreds(hundreds), .tens(tens), .units(units)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: grant bookkeeping and result scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (ack0 || ack1) begin
      checks++;
      if (ack0 && ack1) begin
        errors++;
        $display("[TB] FAIL ack_exclusive: ack0=%0d ack1=%0d, required at most one high", ack0, ack1);
      end
      grant_id.push_back(ack1);
      grant_cyc.push_back(cycle);
    end
    if (res_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_result: id=%0d digits=%0d/%0d/%0d, required no res_valid",
                 res_id, hundreds, tens, units);
      end else begin
        logic [12:0] exp;
        exp = sb.pop_front();
        if ({res_id, hundreds, tens, units} !== exp) begin
          errors++;
          $display("[TB] FAIL result: got id=%0d %0d/%0d/%0d, required id=%0d %0d/%0d/%0d",
                   res_id, hundreds, tens, units, exp[12], exp[11:8], exp[7:4], exp[3:0]);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  // Raise a request, wait (bounded) for its ack, queue the expected result,
  // then drop the request in the ack cycle.
  task automatic applyStimulus(input bit id, input logic [6:0] val,
                               input logic [11:0] exp_bcd, input bit push);
    bit got;
    got = 1'b0;
    if (id) begin
      req1 = 1'b1;
      bin1 = val;
    end else begin
      req0 = 1'b1;
      bin0 = val;
    end
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (id ? ack1 : ack0) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack_timeout: requester %0d got no ack, required ack within 60 cycles", id);
    end else if (push) begin
      sb.push_back({id, exp_bcd});
    end
    if (id) req1 = 1'b0;
    else    req0 = 1'b0;
  endtask

  task automatic waitIdle();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0 && !req0 && !req1) done = 1'b1;
    end
    checkOutput("wait_idle", {31'd0, done}, 32'd1);
  endtask

  logic [6:0]  t2_bin[5] = '{7'd0, 7'd9, 7'd99, 7'd100, 7'd127};
  logic [11:0] t2_exp[5] = '{12'h000, 12'h009, 12'h099, 12'h100, 12'h127};
  bit          t4_order[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ack", {ack0, ack1}, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_digits", {res_id, hundreds, tens, units}, 0);

    // Single conversion with cycle-exact latency
    rst  = 1'b0;
    req0 = 1'b1;
    bin0 = 7'd45;
    sb.push_back({1'b0, 12'h045});
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      checkOutput($sformatf("t1_ack0_c%0d", c), ack0, (c == 1) ? 1 : 0);
      checkOutput($sformatf("t1_busy_c%0d", c), busy, (c <= 8) ? 1 : 0);
      checkOutput($sformatf("t1_valid_c%0d", c), res_valid, (c == 8) ? 1 : 0);
      if (c == 1) req0 = 1'b0;
    end

    // Boundary values on requester 1
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, t2_bin[i], t2_exp[i], 1'b1);
    waitIdle();

    // Tie straight out of reset: req0 first, req1 nine cycles later
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    grant_id.delete();
    grant_cyc.delete();
    fork
      applyStimulus(1'b0, 7'd12, 12'h012, 1'b1);
      applyStimulus(1'b1, 7'd87, 12'h087, 1'b1);
    join
    waitIdle();
    checkOutput("t3_grant_count", grant_id.size(), 2);
    if (grant_id.size() >= 2) begin
      checkOutput("t3_first", grant_id[0], 0);
      checkOutput("t3_second", grant_id[1], 1);
      checkOutput("t3_spacing", grant_cyc[1] - grant_cyc[0], 9);
    end

    // Both requesters continuously pending: grants alternate
    grant_id.delete();
    grant_cyc.delete();
    fork
      begin
        applyStimulus(1'b0, 7'd33, 12'h033, 1'b1);
        applyStimulus(1'b0, 7'd58, 12'h058, 1'b1);
      end
      begin
        applyStimulus(1'b1, 7'd71, 12'h071, 1'b1);
        applyStimulus(1'b1, 7'd104, 12'h104, 1'b1);
      end
    join
    waitIdle();
    checkOutput("t4_grant_count", grant_id.size(), 4);
    for (int i = 0; i < 4 && i < grant_id.size(); i++)
      checkOutput($sformatf("t4_grant%0d", i), grant_id[i], t4_order[i]);

    // Input change after ack leaves the conversion in flight untouched
    applyStimulus(1'b0, 7'd63, 12'h063, 1'b1);
    @(negedge clk);
    bin0 = 7'd5;
    waitIdle();

    // Reset in the 4th SHIFT cycle abandons the conversion
    applyStimulus(1'b0, 7'd77, 12'h000, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_res_valid", res_valid, 0);
    checkOutput("t6_digits", {res_id, hundreds, tens, units}, 0);
    repeat (12) @(negedge clk);
    checkOutput("t6_idle_after", busy, 0);
    applyStimulus(1'b1, 7'd50, 12'h050, 1'b1);
    waitIdle();

    checkOutput("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at 100000, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
